// File: rtl/alu_16_seq.sv
// alu_16_seq: sequences 16-bit Z80-style pair arithmetic/logic through an external 8-bit ALU.
// Optional macro ALU16_SEQ_PERF_EN adds a saturating pass counter output (perf_passes).
module alu_16_seq #(
  parameter logic [4:0] OPC_ADD = 5'd0,
  parameter logic [4:0] OPC_SUB = 5'd1,
  parameter logic [4:0] OPC_AND = 5'd2,
  parameter logic [4:0] OPC_OR  = 5'd3,
  parameter logic [4:0] OPC_XOR = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [7:0]  alu_out
`ifdef ALU16_SEQ_PERF_EN
  ,
  output logic [15:0] perf_passes
`endif
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
  // the response holds data/flags stable from rsp_valid rising until that transfer.

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic [7:0]  res_hi_q, res_hi_d;
  logic        c_lo_q, c_lo_d;
  logic        c_hi_q, c_hi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;

  logic        is_add, is_sub, is_incdec;
  logic [4:0]  opc_sel;
  logic        c_now;
  logic [15:0] word;

  // Carry out of an 8-bit add shows as a wrapped (smaller) result; borrow as a < b.
  function automatic logic carry_of(input logic add, input logic sub,
                                    input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] res);
    if (add) return (res < a);
    if (sub) return (a < b);
    return 1'b0;
  endfunction

  always_comb begin
    is_add    = (op_q == OP_ADD) || (op_q == OP_INC);
    is_sub    = (op_q == OP_SUB) || (op_q == OP_DEC);
    is_incdec = (op_q == OP_INC) || (op_q == OP_DEC);
    case (op_q)
      OP_AND:  opc_sel = OPC_AND;
      OP_OR:   opc_sel = OPC_OR;
      OP_XOR:  opc_sel = OPC_XOR;
      default: opc_sel = is_sub ? OPC_SUB : OPC_ADD;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    c_lo_d      = c_lo_q;
    c_hi_d      = c_hi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_opcode  = 5'd0;
    c_now       = 1'b0;
    word        = {alu_out, res_lo_q};

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          x_d  = req_x;
          y_d  = req_y;
          if (req_op == OP_RSV) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 16'h0000;
            rsp_carry_d = 1'b0;
            rsp_zero_d  = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        alu_a      = x_q[7:0];
        alu_b      = is_incdec ? 8'h01 : y_q[7:0];
        alu_opcode = opc_sel;
        c_now      = carry_of(is_add, is_sub, alu_a, alu_b, alu_out);
        res_lo_d   = alu_out;
        c_lo_d     = c_now;
        state_d    = S_HI;
      end
      S_HI: begin
        alu_a      = x_q[15:8];
        alu_b      = is_incdec ? 8'h00 : y_q[15:8];
        alu_opcode = opc_sel;
        c_now      = carry_of(is_add, is_sub, alu_a, alu_b, alu_out);
        res_hi_d   = alu_out;
        c_hi_d     = c_now;
        if (c_lo_q) begin
          state_d = S_FIX;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = word;
          rsp_carry_d = c_now;
          rsp_zero_d  = (word == 16'h0000);
          rsp_err_d   = 1'b0;
        end
      end
      S_FIX: begin
        // Propagate the low-byte carry/borrow into the high byte.
        alu_a       = res_hi_q;
        alu_b       = 8'h01;
        alu_opcode  = is_add ? OPC_ADD : OPC_SUB;
        c_now       = is_add ? (alu_out == 8'h00) : (res_hi_q == 8'h00);
        res_hi_d    = alu_out;
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = word;
        rsp_carry_d = c_hi_q | c_now;
        rsp_zero_d  = (word == 16'h0000);
        rsp_err_d   = 1'b0;
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      x_q         <= 16'h0000;
      y_q         <= 16'h0000;
      res_lo_q    <= 8'h00;
      res_hi_q    <= 8'h00;
      c_lo_q      <= 1'b0;
      c_hi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      c_lo_q      <= c_lo_d;
      c_hi_q      <= c_hi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU16_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (((state_q == S_LO) || (state_q == S_HI) || (state_q == S_FIX)) &&
        (perf_q != 16'hFFFF))
      perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= 16'h0000;
    else     perf_q <= perf_d;
  end

  assign perf_passes = perf_q;
`endif

endmodule

// File: tb/tb_alu_16_seq.sv
// Testbench for alu_16_seq: directed vector table, hand sequences and random ops vs a 16-bit arithmetic model.
module tb_alu_16_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_out;
`ifdef ALU16_SEQ_PERF_EN
  logic [15:0] perf_passes;
`endif

  int total = 0;
  int bad   = 0;
  int perf_exp = 0;

  // {lat[2:0], err, zero, carry, data[15:0]}
  logic [21:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  alu_16_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out)
`ifdef ALU16_SEQ_PERF_EN
    ,
    .perf_passes(perf_passes)
`endif
  );

  // Behavioural alu_8
  always_comb begin
    case (alu_opcode)
      5'd0:    alu_out = alu_a + alu_b;
      5'd1:    alu_out = alu_a - alu_b;
      5'd2:    alu_out = alu_a & alu_b;
      5'd3:    alu_out = alu_a | alu_b;
      5'd4:    alu_out = alu_a ^ alu_b;
      default: alu_out = 8'h00;
    endcase
  end

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference: plain 16-bit arithmetic; latency follows whether the low byte carries/borrows.
  function automatic logic [21:0] model(input logic [2:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [16:0] s;
    logic [8:0]  sl;
    logic [15:0] d;
    logic        c, e, lo;
    logic [2:0]  lat;
    d = 16'h0; c = 1'b0; e = 1'b0; lo = 1'b0;
    case (op)
      3'd0: begin
        s  = {1'b0, x} + {1'b0, y};
        sl = {1'b0, x[7:0]} + {1'b0, y[7:0]};
        d = s[15:0]; c = s[16]; lo = sl[8];
      end
      3'd1: begin d = x - y; c = (x < y); lo = (x[7:0] < y[7:0]); end
      3'd2: d = x & y;
      3'd3: d = x | y;
      3'd4: d = x ^ y;
      3'd5: begin d = x + 16'd1; c = (x == 16'hFFFF); lo = (x[7:0] == 8'hFF); end
      3'd6: begin d = x - 16'd1; c = (x == 16'h0000); lo = (x[7:0] == 8'h00); end
      default: e = 1'b1;
    endcase
    lat = e ? 3'd1 : (lo ? 3'd4 : 3'd3);
    return {lat, e, (d == 16'h0000), c, d};
  endfunction

  // Called at the first falling edge after acceptance.
  task automatic collect(input int hold, output logic [21:0] got,
                         output logic [7:0] fa, output logic [7:0] fb, output logic [4:0] fo);
    int lat;
    fa = 8'h0; fb = 8'h0; fo = 5'h0; got = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (lat == 3) begin fa = alu_a; fb = alu_b; fo = alu_opcode; end
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    got = {lat[2:0], rsp_err, rsp_zero, rsp_carry, rsp_data};
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Driver: called at a falling edge with the DUT idle.
  task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                        input int hold, output logic [21:0] got,
                        output logic [7:0] fa, output logic [7:0] fb, output logic [4:0] fo);
    logic [21:0] m;
    m = model(op, x, y);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    collect(hold, got, fa, fb, fo);
    perf_exp += (m[21:19] == 3'd1) ? 0 : int'(m[21:19]) - 1;
  endtask

  initial begin
    logic [21:0] got, e;
    logic [7:0]  fa, fb;
    logic [4:0]  fo;
    logic        ok;
    int          n;

    vecs[0]  = '{3'd0, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 1'b0, 4};
    vecs[1]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4};
    vecs[2]  = '{3'd4, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 1'b0, 3};
    vecs[3]  = '{3'd5, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 4};
    vecs[4]  = '{3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b1, 1};
    vecs[5]  = '{3'd6, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4};
    vecs[6]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 3};
    vecs[7]  = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 3};
    vecs[8]  = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 3};
    vecs[9]  = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 3};
    vecs[10] = '{3'd6, 16'h0100, 16'hBEEF, 16'h00FF, 1'b0, 1'b0, 1'b0, 4};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_x = 16'h0; req_y = 16'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_bits", {12'h0, rsp_data, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    chk("reset_alu_bits", {11'h0, alu_a, alu_b, alu_opcode}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, 0, got, fa, fb, fo);
      chk($sformatf("vec%0d_data", i), 32'(got[15:0]), 32'(vecs[i].d));
      chk($sformatf("vec%0d_carry", i), 32'(got[16]), 32'(vecs[i].c));
      chk($sformatf("vec%0d_zero", i), 32'(got[17]), 32'(vecs[i].z));
      chk($sformatf("vec%0d_err", i), 32'(got[18]), 32'(vecs[i].e));
      chk($sformatf("vec%0d_lat", i), 32'(got[21:19]), 32'(vecs[i].lat));
      if (i == 1) begin
        chk("sub_fix_alu_a", 32'(fa), 32'h00);
        chk("sub_fix_alu_b", 32'(fb), 32'h01);
        chk("sub_fix_opcode", 32'(fo), 32'd1);
      end
    end

    // Backpressure with a pending request
    req_valid = 1'b1; req_op = 3'd0; req_x = 16'h0102; req_y = 16'h0304;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_lat", 32'(n), 32'd3);
    req_valid = 1'b1; req_op = 3'd2; req_x = 16'h00FF; req_y = 16'h0F0F;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (rsp_data !== 16'h0406 || rsp_valid !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", 32'(ok), 32'd1);
    chk("bp_data", 32'(rsp_data), 32'h0406);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("bp_idle_after", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_pending_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    collect(0, got, fa, fb, fo);
    chk("bp_pending_data", 32'(got[15:0]), 32'h000F);
    chk("bp_pending_lat", 32'(got[21:19]), 32'd3);
    perf_exp += 4;

    // Reset during the HI pass
    req_valid = 1'b1; req_op = 3'd0; req_x = 16'h1234; req_y = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_rsp", {11'h0, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    chk("rst_mid_alu", {11'h0, alu_a, alu_b, alu_opcode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    perf_exp = 0;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk("rst_mid_no_rsp", 32'(ok), 32'd1);
    run_op(3'd2, 16'hF0F0, 16'h0FF0, 0, got, fa, fb, fo);
    chk("rst_after_and", 32'(got[15:0]), 32'h00F0);

    // Random ops against the model, through the scoreboard queue
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [15:0] x, y;
      op = 3'($urandom_range(0, 7));
      x  = 16'($urandom);
      y  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x[7:0] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      exp_q.push_back(model(op, x, y));
      run_op(op, x, y, $urandom_range(0, 3), got, fa, fb, fo);
      e = exp_q.pop_front();
      chk($sformatf("rand%0d_op%0d_x%04h_y%04h", i, op, x, y), 32'(got), 32'(e));
    end

`ifdef ALU16_SEQ_PERF_EN
    chk("perf_passes", 32'(perf_passes), 32'(perf_exp));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
